// File: rtl/ctrl_pkg.sv
// Shared definitions for the mini-CPU control sequencer: FSM state encoding,
// ALU operation encoding and the opcode values of the instruction set.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2
    } alu_op_t;

    // Opcode values as seen in the upper opcode field of a 4-bit-opcode build.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational opcode decoder. Turns the opcode field of the
// instruction register into the control word consumed by ctrl_sequencer.
// Any opcode not listed in ctrl_pkg is flagged as illegal; whether that traps
// or degrades to a NOP is decided by the sequencer.
module ctrl_decoder #(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] i_opcode,
    output logic             o_reg_we,
    output logic             o_alu_en,
    output logic [1:0]       o_alu_op,
    output logic             o_store_en,
    output logic             o_is_jmp,
    output logic             o_is_jz,
    output logic             o_is_halt,
    output logic             o_illegal
);
    import ctrl_pkg::*;

    // Opcode to control word; everything defaults to an inert NOP first.
    always_comb begin
        o_reg_we   = 1'b0;
        o_alu_en   = 1'b0;
        o_alu_op   = ALU_ADD;
        o_store_en = 1'b0;
        o_is_jmp   = 1'b0;
        o_is_jz    = 1'b0;
        o_is_halt  = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            OPC_W'(OP_NOP): begin
            end
            OPC_W'(OP_LOAD): begin
                o_reg_we = 1'b1;
            end
            OPC_W'(OP_ADD): begin
                o_alu_en = 1'b1;
                o_alu_op = ALU_ADD;
            end
            OPC_W'(OP_SUB): begin
                o_alu_en = 1'b1;
                o_alu_op = ALU_SUB;
            end
            OPC_W'(OP_AND): begin
                o_alu_en = 1'b1;
                o_alu_op = ALU_AND;
            end
            OPC_W'(OP_STORE): begin
                o_store_en = 1'b1;
            end
            OPC_W'(OP_JMP): begin
                o_is_jmp = 1'b1;
            end
            OPC_W'(OP_JZ): begin
                o_is_jz = 1'b1;
            end
            OPC_W'(OP_HALT): begin
                o_is_halt = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer for the mini CPU.
// IDLE -> FETCH -> DECODE -> EXECUTE -> FETCH ... with HALT as a terminal
// state left only through reset. Owns the program counter and instruction
// register and pulses registered one-cycle strobes during EXECUTE.
// Optional feature: define CTRL_SEQ_ILLEGAL_TRAP_EN to make illegal opcodes
// trap (sticky trap + halted, no strobes, PC held); otherwise they run as NOP
// and trap stays 0.
module ctrl_sequencer #(
    parameter int PC_W   = 4,
    parameter int OPC_W  = 4,
    parameter int OPR_W  = 4,
    parameter int REG_AW = 2,
    localparam int INSTR_W = OPC_W + OPR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               zero_flag,
    output logic [PC_W-1:0]    pc,
    output logic               instr_req,
    output logic               reg_we,
    output logic [REG_AW-1:0]  reg_waddr,
    output logic [1:0]         alu_op,
    output logic               alu_en,
    output logic               store_en,
    output logic               halted,
    output logic               trap
);
    import ctrl_pkg::*;

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_next;
    logic [INSTR_W-1:0]  r_ir;
    logic [INSTR_W-1:0]  w_ir_next;
    logic                r_reg_we;
    logic                w_reg_we_next;
    logic                r_alu_en;
    logic                w_alu_en_next;
    logic                r_store_en;
    logic                w_store_en_next;
    logic [1:0]          r_alu_op;
    logic [1:0]          w_alu_op_next;
    logic [REG_AW-1:0]   r_reg_waddr;
    logic [REG_AW-1:0]   w_reg_waddr_next;
    logic                r_halted;
    logic                w_halted_next;
    logic                r_trap;
    logic                w_trap_next;

    logic [OPC_W-1:0]    w_opcode;
    logic [OPR_W-1:0]    w_operand;
    logic [PC_W-1:0]     w_target;
    logic                w_dec_reg_we;
    logic                w_dec_alu_en;
    logic [1:0]          w_dec_alu_op;
    logic                w_dec_store_en;
    logic                w_dec_is_jmp;
    logic                w_dec_is_jz;
    logic                w_dec_is_halt;
    logic                w_dec_illegal;
    logic                w_trap_take;

    assign w_opcode  = r_ir[INSTR_W-1 -: OPC_W];
    assign w_operand = r_ir[OPR_W-1:0];
    // Operand is zero-extended or truncated to the PC width.
    assign w_target  = PC_W'(w_operand);
    // In the default build this folds to 0 and illegal opcodes behave as NOP.
    assign w_trap_take = TRAP_EN && w_dec_illegal;

    ctrl_decoder #(
        .OPC_W (OPC_W)
    ) u_decoder (
        .i_opcode   (w_opcode),
        .o_reg_we   (w_dec_reg_we),
        .o_alu_en   (w_dec_alu_en),
        .o_alu_op   (w_dec_alu_op),
        .o_store_en (w_dec_store_en),
        .o_is_jmp   (w_dec_is_jmp),
        .o_is_jz    (w_dec_is_jz),
        .o_is_halt  (w_dec_is_halt),
        .o_illegal  (w_dec_illegal)
    );

    // Next-state, next-PC and next-output computation; strobes default low.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_ir_next        = r_ir;
        w_reg_we_next    = 1'b0;
        w_alu_en_next    = 1'b0;
        w_store_en_next  = 1'b0;
        w_alu_op_next    = r_alu_op;
        w_reg_waddr_next = r_reg_waddr;
        w_halted_next    = r_halted;
        w_trap_next      = r_trap;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    w_ir_next    = instr;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_next = ST_EXECUTE;
                if (!w_trap_take) begin
                    w_reg_we_next    = w_dec_reg_we;
                    w_alu_en_next    = w_dec_alu_en;
                    w_store_en_next  = w_dec_store_en;
                    w_reg_waddr_next = w_operand[REG_AW-1:0];
                    if (w_dec_alu_en) begin
                        w_alu_op_next = w_dec_alu_op;
                    end
                end
            end
            ST_EXECUTE: begin
                if (w_trap_take) begin
                    w_state_next  = ST_HALT;
                    w_halted_next = 1'b1;
                    w_trap_next   = 1'b1;
                end else if (w_dec_is_halt) begin
                    w_state_next  = ST_HALT;
                    w_halted_next = 1'b1;
                end else begin
                    w_state_next = ST_FETCH;
                    if (w_dec_is_jmp || (w_dec_is_jz && zero_flag)) begin
                        w_pc_next = w_target;
                    end else begin
                        w_pc_next = r_pc + PC_W'(1);
                    end
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, IR, strobe and status registers; reset clears strobes at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_reg_we    <= 1'b0;
            r_alu_en    <= 1'b0;
            r_store_en  <= 1'b0;
            r_alu_op    <= ALU_ADD;
            r_reg_waddr <= '0;
            r_halted    <= 1'b0;
            r_trap      <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_ir        <= w_ir_next;
            r_reg_we    <= w_reg_we_next;
            r_alu_en    <= w_alu_en_next;
            r_store_en  <= w_store_en_next;
            r_alu_op    <= w_alu_op_next;
            r_reg_waddr <= w_reg_waddr_next;
            r_halted    <= w_halted_next;
            r_trap      <= w_trap_next;
        end
    end

    assign pc        = r_pc;
    assign instr_req = (r_state == ST_FETCH);
    assign reg_we    = r_reg_we;
    assign alu_en    = r_alu_en;
    assign store_en  = r_store_en;
    assign alu_op    = r_alu_op;
    assign reg_waddr = r_reg_waddr;
    assign halted    = r_halted;
    assign trap      = r_trap;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard testbench for ctrl_sequencer (default parameters, 8-bit
// instructions). Stimulus pushes the hand-computed result of each instruction
// into a queue; the monitor pops one entry per accepted fetch and checks the
// decode, execute and post-execute cycles. Honours CTRL_SEQ_ILLEGAL_TRAP_EN.
module tb_ctrl_sequencer;

    typedef struct {
        logic [7:0] instr;
        bit         zf;
        int         stall;
        bit         we;
        bit         alu;
        bit         st;
        logic [1:0] op;
        logic [1:0] wa;
        logic [3:0] fpc;
        logic [3:0] npc;
        bit         halted;
        bit         trap;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] instr;
    logic       instr_valid;
    logic       zero_flag;
    logic [3:0] pc;
    logic       instr_req;
    logic       reg_we;
    logic [1:0] reg_waddr;
    logic [1:0] alu_op;
    logic       alu_en;
    logic       store_en;
    logic       halted;
    logic       trap;

    int   compared   = 0;
    int   mismatched = 0;
    bit   monEn      = 1'b1;
    vec_t expQ[$];

    ctrl_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .instr       (instr),
        .instr_valid (instr_valid),
        .zero_flag   (zero_flag),
        .pc          (pc),
        .instr_req   (instr_req),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .alu_op      (alu_op),
        .alu_en      (alu_en),
        .store_en    (store_en),
        .halted      (halted),
        .trap        (trap)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] i, input bit zf, input int stall,
                                input bit we, input bit alu, input bit st,
                                input logic [1:0] op, input logic [1:0] wa,
                                input logic [3:0] fpc, input logic [3:0] npc,
                                input bit h, input bit t);
        vec_t v;
        v.instr = i;  v.zf = zf;   v.stall = stall;
        v.we = we;    v.alu = alu; v.st = st;
        v.op = op;    v.wa = wa;   v.fpc = fpc; v.npc = npc;
        v.halted = h; v.trap = t;
        return v;
    endfunction

    // Issue one instruction: wait for the fetch request, stall if asked, then
    // present it. valid stays high with a HALT word through DECODE/EXECUTE to
    // show it is ignored there, and zero_flag is only correct in EXECUTE.
    task automatic applyStimulus(input vec_t v);
        int waitCnt;
        expQ.push_back(v);
        waitCnt = 0;
        while (!instr_req && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!instr_req) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL fetch_timeout: instr_req=%0b, expected 1", instr_req);
            expQ.delete(expQ.size() - 1);
            return;
        end
        instr_valid = 1'b0;
        instr       = 8'hF0;
        repeat (v.stall) begin
            @(posedge clk); #1;
        end
        instr       = v.instr;
        instr_valid = 1'b1;
        zero_flag   = ~v.zf;
        @(posedge clk); #1;
        instr       = 8'hF0;
        @(posedge clk); #1;
        zero_flag   = v.zf;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        zero_flag   = ~v.zf;
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        run         = 1'b0;
        instr_valid = 1'b0;
        instr       = 8'h00;
        zero_flag   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_instr_req", instr_req, 0);
        checkOutput("rst_strobes", {reg_we, alu_en, store_en}, 0);
        checkOutput("rst_alu_op", alu_op, 0);
        checkOutput("rst_reg_waddr", reg_waddr, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_trap", trap, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Monitor: tracks each accepted fetch through DECODE (+1), EXECUTE (+2)
    // and the following cycle (+3), and checks PC stability while stalled.
    initial begin : monitor
        vec_t p1, p2, p3;
        bit   v1, v2, v3;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !monEn) begin
                v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
                continue;
            end
            if (v3) begin
                checkOutput("next_pc", pc, p3.npc);
                checkOutput("halted", halted, p3.halted);
                checkOutput("trap", trap, p3.trap);
            end
            if (v2) begin
                checkOutput("exec_reg_we", reg_we, p2.we);
                checkOutput("exec_alu_en", alu_en, p2.alu);
                checkOutput("exec_store_en", store_en, p2.st);
                if (p2.alu) checkOutput("exec_alu_op", alu_op, p2.op);
                if (p2.we)  checkOutput("exec_reg_waddr", reg_waddr, p2.wa);
            end
            if (v1) begin
                checkOutput("decode_strobes", {reg_we, alu_en, store_en}, 0);
            end
            p3 = p2; v3 = v2;
            p2 = p1; v2 = v1;
            v1 = 1'b0;
            if (instr_req) begin
                if (expQ.size() == 0) begin
                    if (instr_valid) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_fetch: pc=%0h with empty scoreboard", pc);
                    end
                end else if (instr_valid) begin
                    p1 = expQ.pop_front();
                    v1 = 1'b1;
                    checkOutput("fetch_pc", pc, p1.fpc);
                end else begin
                    checkOutput("stall_pc", pc, expQ[0].fpc);
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        // Phase 1: LOAD 0x12, ADD, STORE (4-cycle stall at pc 2), HALT.
        doReset();
        run = 1'b1;
        applyStimulus(mk(8'h12, 0, 0, 1, 0, 0, 2'd0, 2'd2, 4'd0, 4'd1, 0, 0));
        applyStimulus(mk(8'h40, 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'd1, 4'd2, 0, 0));
        applyStimulus(mk(8'h60, 0, 4, 0, 0, 1, 2'd0, 2'd0, 4'd2, 4'd3, 0, 0));
        applyStimulus(mk(8'hF0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd3, 4'd3, 1, 0));
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("halt_instr_req", instr_req, 0);
        checkOutput("halt_pc", pc, 3);
        checkOutput("halt_sticky", halted, 1);

        // Phase 2: run pulsed for one cycle only; jumps, branches, wrap, illegal.
        doReset();
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        applyStimulus(mk(8'h8A, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0,  4'd10, 0, 0));
        applyStimulus(mk(8'h53, 0, 0, 0, 1, 0, 2'd1, 2'd0, 4'd10, 4'd11, 0, 0));
        applyStimulus(mk(8'h71, 0, 1, 0, 1, 0, 2'd2, 2'd0, 4'd11, 4'd12, 0, 0));
        applyStimulus(mk(8'h97, 1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd12, 4'd7,  0, 0));
        applyStimulus(mk(8'h97, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd7,  4'd8,  0, 0));
        applyStimulus(mk(8'h8F, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd8,  4'd15, 0, 0));
        applyStimulus(mk(8'h00, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd15, 4'd0,  0, 0));
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
        applyStimulus(mk(8'hC5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0,  4'd0,  1, 1));
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("trap_instr_req", instr_req, 0);
`else
        applyStimulus(mk(8'hC5, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0,  4'd1,  0, 0));
        applyStimulus(mk(8'h1D, 0, 0, 1, 0, 0, 2'd0, 2'd1, 4'd1,  4'd2,  0, 0));
        applyStimulus(mk(8'hF0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd2,  4'd2,  1, 0));
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("halt2_instr_req", instr_req, 0);
`endif

        // Phase 3: asynchronous reset in the EXECUTE cycle of an ADD.
        doReset();
        monEn = 1'b0;
        run   = 1'b1;
        @(posedge clk); #1;
        checkOutput("p3_fetch_req", instr_req, 1);
        instr       = 8'h40;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("p3_exec_alu_en", alu_en, 1);
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        checkOutput("p3_async_alu_en", alu_en, 0);
        checkOutput("p3_async_pc", pc, 0);
        checkOutput("p3_async_instr_req", instr_req, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("p3_idle_without_run", instr_req, 0);
        run = 1'b1;
        @(posedge clk); #1;
        checkOutput("p3_restart_req", instr_req, 1);
        checkOutput("p3_restart_pc", pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised multi-cycle instruction sequencer for the mini CPU, replacing the fixed 8-bit/4-bit-PC control FSM. It fetches from instruction memory with a valid handshake, decodes one instruction per pass and pulses one-cycle control strobes to the register file, ALU and store path. It also owns the program counter, adds jump, branch-on-zero and halt, and sits between instruction memory and the datapath.

## Interface
Parameters:
- `PC_W`, 4, program counter width; PC wraps modulo 2^PC_W
- `OPC_W`, 4, opcode field width; opcode is `instr[INSTR_W-1 -: OPC_W]`
- `OPR_W`, 4, operand field width; operand is `instr[OPR_W-1:0]`; `INSTR_W = OPC_W + OPR_W`
- `REG_AW`, 2, register-file address width (must be ≤ OPR_W)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  the single clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; leaves IDLE when high
- `instr`  in  INSTR_W  instruction word from instruction memory
- `instr_valid`  in  1  `instr` valid this cycle
- `zero_flag`  in  1  ALU zero result, sampled in EXECUTE
- `pc`  out  PC_W  fetch address, registered
- `instr_req`  out  1  fetch request, high in FETCH
- `reg_we`  out  1  register-file write strobe
- `reg_waddr`  out  REG_AW  write address = `operand[REG_AW-1:0]`
- `alu_op`  out  2  0 = ADD, 1 = SUB, 2 = AND
- `alu_en`  out  1  ALU execute strobe
- `store_en`  out  1  store strobe
- `halted`  out  1  sticky; high in HALT
- `trap`  out  1  sticky illegal-opcode flag (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, HALT.
  - IDLE→FETCH when `run`.
  - FETCH→DECODE when `instr_valid`; stays in FETCH otherwise. `instr` is latched into IR.
  - DECODE→EXECUTE unconditionally.
  - EXECUTE→FETCH, or →HALT for HALT or trap.
  - HALT exits only via reset.
- Opcodes (upper OPC_W bits, values for OPC_W=4):
  - 0x0: NOP.
  - 0x1: LOAD; `reg_we` = 1.
  - 0x4: ADD; `alu_en` = 1, `alu_op` = 0.
  - 0x5: SUB; `alu_op` = 1.
  - 0x7: AND; `alu_op` = 2.
  - 0x6: STORE; `store_en` = 1.
  - 0x8: JMP; PC ← operand.
  - 0x9: JZ; PC ← operand if `zero_flag`, else PC + 1.
  - 0xF: HALT.
  - All other values are illegal.
- Jump target: operand zero-extended or truncated to PC_W.
- Strobes (`reg_we`, `alu_en`, `store_en`) are registered. They are set on the DECODE→EXECUTE edge and are high exactly during the EXECUTE cycle, otherwise 0.
- `alu_op` and `reg_waddr` hold their last decoded value between instructions.
- PC updates on the EXECUTE→next edge only: PC + 1 (with wrap), or the jump target. A fetch stall never advances PC.
- `run` is sampled only in IDLE; deasserting it mid-program has no effect.

## Timing
- Reset values: state IDLE, `pc` = 0, IR = 0, every strobe 0, `alu_op` = 0, `reg_waddr` = 0, `instr_req` = 0, `halted` = 0, `trap` = 0.
- With `instr_valid` high in cycle N (FETCH): DECODE at N+1, strobes high at N+2, FETCH at N+3 with the new `pc`. Three cycles per instruction with no wait states.
- Each cycle of `instr_valid` low in FETCH adds one cycle; `pc` and `instr_req` stay stable.
- `instr_valid` outside FETCH is ignored.
- `pc` = 2^PC_W−1 plus a non-jump instruction wraps to 0.
- JZ uses `zero_flag` as sampled in the EXECUTE cycle only.
- Asynchronous reset mid-EXECUTE clears strobes immediately; no partial PC update.
- `halted` rises on the edge leaving EXECUTE of a HALT instruction.

## Configuration
- `CTRL_SEQ_ILLEGAL_TRAP_EN`
  - Defined: an illegal opcode produces no strobes, sets `trap` = 1 and `halted` = 1, and enters HALT; PC is not advanced.
  - Undefined: an illegal opcode executes as NOP and `trap` is tied to 0.

## Structure
- Shared package `ctrl_pkg` holds the opcode constants, the state encoding (3-bit) and the `alu_op` encoding.
- Sub-module `ctrl_decoder` is purely combinational: IR opcode → control word {`reg_we`, `alu_en`, `alu_op`, `store_en`, `is_jmp`, `is_jz`, `is_halt`, `illegal`}. The FSM, IR, PC and output registers live in `ctrl_sequencer`.

## Test plan
- Reset, then `run` = 1, `instr_valid` always 1, program LOAD 0x12, ADD, STORE, HALT → `reg_we`, `alu_en` (`alu_op` = 0), `store_en` each high for one cycle at cycles 2, 5 and 8; `halted` = 1 after the 4th instruction; `pc` = 3.
- `instr_valid` held low 4 cycles in FETCH at `pc` = 2 → `instr_req` = 1 and `pc` = 2 throughout; the instruction then completes 3 cycles after valid.
- JZ 0x7 with `zero_flag` = 1 → next `pc` = 7. Same instruction with `zero_flag` = 0 → `pc` + 1.
- PC_W = 4, NOP at `pc` = 15 → next `pc` = 0. JMP 0xA → `pc` = 10.
- Opcode 0xC with the macro defined → `trap` = `halted` = 1 and no strobes. Without the macro → behaves as NOP, `pc` advances.
- `rst_n` pulsed low during EXECUTE of ADD → `alu_en` drops asynchronously, `pc` = 0, state IDLE; restart requires `run`.
